// File: rtl/rtl_settings_pkg.sv
// Shared types and helpers for the ranged address generator:
// mode encoding, FSM states and the maximal-length LFSR tap table.
package rtl_settings_pkg;

  typedef enum logic [2:0] {
    FIX   = 3'd0,
    RND   = 3'd1,
    RUN_0 = 3'd2,
    RUN_1 = 3'd3,
    INC   = 3'd4,
    DEC   = 3'd5
  } addr_gen_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } addr_gen_state_t;

  // Tap mask (bit i set = bit i feeds the XOR) for a left-shifting
  // Fibonacci LFSR of the given width; only 8/16/24/32 are supported.
  function automatic logic [31:0] LFSR_TAPS(input int width);
    case (width)
      8:       return 32'h0000_00B8;  // 7,5,4,3
      16:      return 32'h0000_D008;  // 15,14,12,3
      24:      return 32'h00E1_0000;  // 23,22,21,16
      32:      return 32'h8020_0003;  // 31,21,1,0
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Map the raw mode field onto the enum; codes 6 and 7 act as FIX.
  function automatic addr_gen_mode_t decode_mode(input logic [2:0] m);
    if (m > 3'd5) return FIX;
    return addr_gen_mode_t'(m);
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Left-shifting Fibonacci LFSR with synchronous seed load.
// A zero seed would lock the register, so it is replaced by all-ones.
module lfsr_gen
  import rtl_settings_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             shift_i,
  output logic [WIDTH-1:0] value_o
);

  localparam logic [31:0]      TAPS_ALL = LFSR_TAPS(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_q;
  logic             feedback;

  assign feedback = ^(lfsr_q & TAPS);
  assign value_o  = lfsr_q;

  // State register: load wins over shift.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lfsr_q <= '1;
    end else if (load_i) begin
      lfsr_q <= (seed_i == '0) ? '1 : seed_i;
    end else if (shift_i) begin
      lfsr_q <= {lfsr_q[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/addr_gen_ranged.sv
// Ranged test-address generator: latches parameters on start and streams
// trans_cnt addresses over valid/ready, then pulses done.
// Build option: ADDR_GEN_STRIDE_EN makes the INC/DEC step the latched
// stride_i (0 treated as 1); otherwise the step is 1 and stride_i is unused.
module addr_gen_ranged
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int LFSR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [2:0]        mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic [ADDR_W-1:0] addr_mask_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [CNT_W-1:0]  trans_cnt_i,
  input  logic              addr_ready_i,
  output logic              addr_valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o
);

  addr_gen_state_t   state_q, state_d;
  addr_gen_mode_t    mode_q, mode_in;
  logic [ADDR_W-1:0] base_q, last_q, mask_q, addr_q;
  logic [ADDR_W-1:0] step, first_addr, next_addr;
  logic [CNT_W-1:0]  remaining_q;
  logic              done_q, done_d;
  logic              load, advance, clear;
  logic [ADDR_W:0]   sum_w, diff_w;
  logic [LFSR_W-1:0] lfsr_value;

  assign mode_in = decode_mode(mode_i);

`ifdef ADDR_GEN_STRIDE_EN
  logic [ADDR_W-1:0] step_q;

  // Stride is latched with the other parameters; zero means unit step.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  step_q <= ADDR_W'(1);
    else if (load) step_q <= (stride_i == '0) ? ADDR_W'(1) : stride_i;
  end
  assign step = step_q;
`else
  logic unused_stride;
  assign unused_stride = ^stride_i;
  assign step          = ADDR_W'(1);
`endif

  lfsr_gen #(.WIDTH(LFSR_W)) u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (load),
    .seed_i  (seed_i),
    .shift_i (advance),
    .value_o (lfsr_value)
  );

  if (LFSR_W > ADDR_W) begin : g_lfsr_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_value[LFSR_W-1:ADDR_W];
  end

  // Next-state decode; abort beats a same-cycle transfer, start beats abort in IDLE.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load = 1'b1;
          if (trans_cnt_i == '0) done_d  = 1'b1;
          else                   state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end else if (addr_ready_i) begin
          advance = 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // First address of a stream, taken from the live inputs at start.
  always_comb begin
    first_addr = base_addr_i;
    case (mode_in)
      RUN_0:   first_addr = {{(ADDR_W-1){1'b1}}, 1'b0};
      RUN_1:   first_addr = ADDR_W'(1);
      DEC:     first_addr = (base_addr_i > last_addr_i) ? base_addr_i : last_addr_i;
      default: first_addr = base_addr_i;
    endcase
  end

  // One extra bit catches overflow on INC and underflow on DEC.
  assign sum_w  = {1'b0, addr_q} + {1'b0, step};
  assign diff_w = {1'b0, addr_q} - {1'b0, step};

  // Address following a transfer; INC/DEC wrap inside [base, last].
  always_comb begin
    next_addr = addr_q;
    case (mode_q)
      RUN_0, RUN_1: next_addr = {addr_q[ADDR_W-2:0], addr_q[ADDR_W-1]};
      INC: begin
        if (base_q > last_q)                              next_addr = base_q;
        else if (sum_w[ADDR_W] || sum_w[ADDR_W-1:0] > last_q) next_addr = base_q;
        else                                              next_addr = sum_w[ADDR_W-1:0];
      end
      DEC: begin
        if (base_q > last_q)                                   next_addr = base_q;
        else if (diff_w[ADDR_W] || diff_w[ADDR_W-1:0] < base_q) next_addr = last_q;
        else                                                   next_addr = diff_w[ADDR_W-1:0];
      end
      default: next_addr = addr_q;
    endcase
  end

  // FSM state and done pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Latched parameters, address register and transfer counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q      <= FIX;
      base_q      <= '0;
      last_q      <= '0;
      mask_q      <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
    end else if (load) begin
      mode_q      <= mode_in;
      base_q      <= base_addr_i;
      last_q      <= last_addr_i;
      mask_q      <= addr_mask_i;
      addr_q      <= first_addr;
      remaining_q <= trans_cnt_i;
    end else if (advance) begin
      addr_q      <= next_addr;
      remaining_q <= remaining_q - CNT_W'(1);
    end else if (clear) begin
      remaining_q <= '0;
    end
  end

  // RND addresses come straight from the LFSR register through the mask.
  assign addr_o       = (mode_q == RND) ? (lfsr_value[ADDR_W-1:0] & mask_q) : addr_q;
  assign addr_valid_o = (state_q == ST_RUN);
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = done_q;

endmodule

// File: tb/tb_addr_gen_ranged.sv
// Bench for addr_gen_ranged (ADDR_W=16, LFSR_W=16): a stream-level model
// builds each expected address list from the mode rules and a negedge
// compare process checks valid/busy/done/addr every cycle.
module tb_addr_gen_ranged;

  logic        clk_i, rst_n_i, start_i, abort_i, addr_ready_i;
  logic [2:0]  mode_i;
  logic [15:0] base_addr_i, last_addr_i, addr_mask_i, seed_i, stride_i;
  logic [31:0] trans_cnt_i;
  logic        addr_valid_o, busy_o, done_o;
  logic [15:0] addr_o;

  addr_gen_ranged #(.ADDR_W(16), .LFSR_W(16), .CNT_W(32)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .mode_i       (mode_i),
    .base_addr_i  (base_addr_i),
    .last_addr_i  (last_addr_i),
    .addr_mask_i  (addr_mask_i),
    .seed_i       (seed_i),
    .stride_i     (stride_i),
    .trans_cnt_i  (trans_cnt_i),
    .addr_ready_i (addr_ready_i),
    .addr_valid_o (addr_valid_o),
    .addr_o       (addr_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int exp_q[$];
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_rem  = 0;
  int m_idx  = 0;

  bit          track_rnd = 1'b0;
  bit          seen [65536];
  int          rnd_n = 0, repeats = 0, distinct = 0;
  logic [15:0] wrap_addr = '0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    // x^16 + x^15 + x^13 + x^4 + 1
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic void build_list(input int mode, input int base, input int last,
                                     input int mask, input int seed, input int stride,
                                     input int cnt);
    int a, st;
    logic [15:0] s;
    exp_q.delete();
    st = 1;
`ifdef ADDR_GEN_STRIDE_EN
    st = (stride == 0) ? 1 : stride;
`endif
    s = (seed == 0) ? 16'hFFFF : 16'(seed);
    case (mode)
      2:       a = 16'hFFFE;
      3:       a = 1;
      5:       a = (base > last) ? base : last;
      default: a = base;
    endcase
    for (int i = 0; i < cnt; i++) begin
      if (mode == 1) begin
        exp_q.push_back(int'(s) & mask);
        s = lfsr_next(s);
      end else begin
        exp_q.push_back(a);
        case (mode)
          2, 3: a = ((a << 1) | (a >> 15)) & 16'hFFFF;
          4: begin
            if (base > last || a + st > last) a = base;
            else                              a = a + st;
          end
          5: begin
            if (base > last)       a = base;
            else if (a - st < base) a = last;
            else                   a = a - st;
          end
          default: ;
        endcase
      end
    end
  endfunction

  // Compare current outputs with the model, then advance the model to the next edge.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      check("rst_valid", 32'(addr_valid_o), 0);
      check("rst_busy",  32'(busy_o), 0);
      check("rst_done",  32'(done_o), 0);
      check("rst_addr",  32'(addr_o), 0);
      m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_idx = 0;
    end else begin
      check("valid", 32'(addr_valid_o), 32'(m_busy));
      check("busy",  32'(busy_o), 32'(m_busy));
      check("done",  32'(done_o), 32'(m_done));
      if (m_busy) check("addr", 32'(addr_o), exp_q[m_idx]);
      m_done = 1'b0;
      if (!m_busy) begin
        if (start_i) begin
          build_list(int'(mode_i), int'(base_addr_i), int'(last_addr_i), int'(addr_mask_i),
                     int'(seed_i), int'(stride_i), int'(trans_cnt_i));
          if (trans_cnt_i == 0) m_done = 1'b1;
          else begin m_busy = 1'b1; m_rem = int'(trans_cnt_i); m_idx = 0; end
        end
      end else if (abort_i) begin
        m_busy = 1'b0;
      end else if (addr_ready_i) begin
        if (track_rnd) begin
          if (rnd_n < 65535) begin
            if (seen[addr_o]) repeats++;
            else begin seen[addr_o] = 1'b1; distinct++; end
          end else if (rnd_n == 65535) wrap_addr = addr_o;
          rnd_n++;
        end
        m_idx++;
        m_rem--;
        if (m_rem == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ready_pct < 0 toggles ready 1/0; abort_at is the transfer index to abort on (-1 none).
  task automatic run_stream(input int mode, input int base, input int last, input int mask,
                            input int seed, input int stride, input int cnt,
                            input int ready_pct, input int abort_at, input int abort_pct,
                            input bit abort_with_start);
    int cyc;
    mode_i = 3'(mode); base_addr_i = 16'(base); last_addr_i = 16'(last);
    addr_mask_i = 16'(mask); seed_i = 16'(seed); stride_i = 16'(stride);
    trans_cnt_i = 32'(cnt);
    abort_i = abort_with_start;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    cyc = 0;
    while (m_busy && cyc < 70000) begin
      if (ready_pct < 0) addr_ready_i = (cyc % 2 == 0);
      else               addr_ready_i = ($urandom_range(1, 100) <= ready_pct);
      abort_i = (abort_at >= 0 && m_idx == abort_at) || ($urandom_range(1, 100) <= abort_pct);
      // Parameter changes and start pulses while busy must be ignored.
      start_i     = ($urandom_range(0, 9) == 0);
      mode_i      = 3'($urandom);
      base_addr_i = 16'($urandom);
      last_addr_i = 16'($urandom);
      addr_mask_i = 16'($urandom);
      seed_i      = 16'($urandom);
      stride_i    = 16'($urandom);
      trans_cnt_i = 32'($urandom_range(0, 5));
      tick();
      cyc++;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    if (m_busy) check("stream_timeout", 1, 0);
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1[6] = '{'h10, 'h11, 'h12, 'h13, 'h10, 'h11};
    int t2[4] = '{'h12, 'h11, 'h10, 'h12};
    int b, l;

    rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; addr_ready_i = 1'b0;
    mode_i = '0; base_addr_i = '0; last_addr_i = '0; addr_mask_i = '0;
    seed_i = '0; stride_i = '0; trans_cnt_i = '0;
    #2;
    check("por_valid", 32'(addr_valid_o), 0);
    check("por_addr",  32'(addr_o), 0);
    repeat (3) tick();
    rst_n_i = 1'b1;
    tick();

    // 1: INC wrap inside [0x10, 0x13]
    run_stream(4, 'h10, 'h13, 'hFFFF, 1, 1, 6, 100, -1, 0, 1'b0);
    for (int i = 0; i < 6; i++) check("t1_model", exp_q[i], t1[i]);

    // 2: DEC with toggling ready
    run_stream(5, 'h10, 'h12, 'hFFFF, 1, 1, 4, -1, -1, 0, 1'b0);
    for (int i = 0; i < 4; i++) check("t2_model", exp_q[i], t2[i]);

    // 4: RUN_1 rotation through all 16 bits and back
    run_stream(3, 0, 0, 'hFFFF, 1, 1, 17, 100, -1, 0, 1'b0);
    check("t4_first", exp_q[0], 'h0001);
    check("t4_top",   exp_q[15], 'h8000);
    check("t4_wrap",  exp_q[16], 'h0001);

    // 5a: zero-length stream, with a simultaneous abort that start must override
    mode_i = 3'd4; base_addr_i = 16'h20; last_addr_i = 16'h30; trans_cnt_i = '0;
    abort_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    check("t5_done_n1", 32'(done_o), 1);
    check("t5_novalid", 32'(addr_valid_o), 0);
    check("t5_nobusy",  32'(busy_o), 0);
    tick();
    check("t5_done_gone", 32'(done_o), 0);

    // 5b: abort on the third of ten transfers
    run_stream(4, 0, 'h100, 'hFFFF, 1, 1, 10, 100, 2, 0, 1'b0);
    check("t5_abort_busy",  32'(busy_o), 0);
    check("t5_abort_valid", 32'(addr_valid_o), 0);
    check("t5_abort_done",  32'(done_o), 0);

    // start together with abort in IDLE: the stream still runs
    run_stream(2, 0, 0, 'hFFFF, 1, 1, 3, 100, -1, 0, 1'b1);
    check("t_sa_model", exp_q[1], 'hFFFD);

`ifdef ADDR_GEN_STRIDE_EN
    // 6: strided INC
    run_stream(4, 0, 'h0F, 'hFFFF, 1, 6, 4, 100, -1, 0, 1'b0);
    check("t6_a1", exp_q[1], 'h06);
    check("t6_a2", exp_q[2], 'h0C);
    check("t6_a3", exp_q[3], 'h00);
`endif

    // async reset in the middle of a stream
    mode_i = 3'd4; base_addr_i = 16'h0; last_addr_i = 16'h100; trans_cnt_i = 32'd10;
    addr_ready_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_valid", 32'(addr_valid_o), 0);
    check("arst_busy",  32'(busy_o), 0);
    check("arst_done",  32'(done_o), 0);
    check("arst_addr",  32'(addr_o), 0);
    tick();
    rst_n_i = 1'b1;
    repeat (2) tick();

    // randomized streams
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        b = $urandom_range(65500, 65535); l = $urandom_range(65500, 65535);
      end else begin
        b = $urandom_range(0, 40); l = $urandom_range(0, 40);
      end
      run_stream($urandom_range(0, 7), b, l, $urandom_range(0, 65535),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535),
                 $urandom_range(0, 5), $urandom_range(0, 20),
                 $urandom_range(50, 100), -1, ($urandom_range(0, 1) == 0) ? 0 : 5, 1'b0);
    end

    // 3: RND full period from seed 0
    track_rnd = 1'b1;
    run_stream(1, 0, 0, 'hFFFF, 0, 1, 65536, 100, -1, 0, 1'b0);
    track_rnd = 1'b0;
    check("t3_first",    exp_q[0], 'hFFFF);
    check("t3_second",   exp_q[1], 'hFFFE);
    check("t3_third",    exp_q[2], 'hFFFC);
    check("t3_distinct", 32'(distinct), 65535);
    check("t3_repeats",  32'(repeats), 0);
    check("t3_wrap",     32'(wrap_addr), 'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
